neuron_mac: RTL



---
 rtl/neuron_mac_if.sv | 38 +++
 rtl/neuron_mac.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/neuron_mac_if.sv
`default_nettype none
// ============================================================================
// Module      : neuron_mac_if
// Description : Weight/bias load bus, input sample stream and sum output of
//               the neuron_mac stage, bundled for port connection.
// Revision    : 1.0 - initial release
// ============================================================================
interface neuron_mac_if #(
  parameter int dataWidth    = 16,
  parameter int addressWidth = 10
);
  logic                      weight_wr_en;
  logic [addressWidth-1:0]   weight_wr_addr;
  logic [dataWidth-1:0]      weight_wr_data;
  logic                      bias_wr_en;
  logic [2*dataWidth-1:0]    bias_wr_data;
  logic                      x_valid;
  logic [dataWidth-1:0]      x_in;
  logic [2*dataWidth-1:0]    sum_out;
  logic                      sum_valid;

  // Producer side: loads weights/bias, streams samples, receives sums
  modport master (
    output weight_wr_en, weight_wr_addr, weight_wr_data,
    output bias_wr_en, bias_wr_data,
    output x_valid, x_in,
    input  sum_out, sum_valid
  );

  // MAC side
  modport slave (
    input  weight_wr_en, weight_wr_addr, weight_wr_data,
    input  bias_wr_en, bias_wr_data,
    input  x_valid, x_in,
    output sum_out, sum_valid
  );
endinterface
`default_nettype wire

// File: rtl/neuron_mac.sv
`default_nettype none
// ============================================================================
// Module      : neuron_mac
// Description : Per-neuron multiply-accumulate feeding the ReLU stage.
//               Three-stage pipeline: weight read / sample register,
//               exact signed product, saturating accumulate on top of bias.
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_mac #(
  parameter int dataWidth      = 16,
  parameter int weightIntWidth = 4,
  parameter int numWeight      = 784,
  parameter int addressWidth   = 10
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  neuron_mac_if.slave   bus
);

  localparam int c_aw = 2 * dataWidth;
  localparam int c_cw = (numWeight > 1) ? $clog2(numWeight) : 1;
  localparam logic [addressWidth-1:0] c_last_addr = addressWidth'(numWeight - 1);
  localparam logic [c_cw-1:0]         c_last_idx  = c_cw'(numWeight - 1);
  localparam logic signed [c_aw-1:0]  c_sat_max   = {1'b0, {(c_aw-1){1'b1}}};
  localparam logic signed [c_aw-1:0]  c_sat_min   = {1'b1, {(c_aw-1){1'b0}}};

  // Reject parameter sets the pipeline cannot honour (weight format wider
  // than the sample, too few weights, or an address space too small).
  generate
    if (weightIntWidth > dataWidth || numWeight < 2 ||
        (2 ** addressWidth) < numWeight) begin : g_bad_params
      $error("neuron_mac: illegal parameter combination");
    end
  endgenerate

  // Signed add that clamps instead of wrapping when both operands share a
  // sign and the result flips it.
  function automatic logic signed [c_aw-1:0] sat_add(
    input logic signed [c_aw-1:0] a,
    input logic signed [c_aw-1:0] b
  );
    logic signed [c_aw-1:0] s;
    s = a + b;
    if (!a[c_aw-1] && !b[c_aw-1] && s[c_aw-1])
      sat_add = c_sat_max;
    else if (a[c_aw-1] && b[c_aw-1] && !s[c_aw-1])
      sat_add = c_sat_min;
    else
      sat_add = s;
  endfunction

  logic signed [dataWidth-1:0] r_mem [0:numWeight-1];
  logic [addressWidth-1:0]     r_raddr;
  logic signed [dataWidth-1:0] r_weight;
  logic signed [dataWidth-1:0] r_x;
  logic                        r_v1;
  logic signed [c_aw-1:0]      r_prod;
  logic                        r_v2;
  logic [c_cw-1:0]             r_idx;
  logic signed [c_aw-1:0]      r_acc;
  logic signed [c_aw-1:0]      r_bias;
  logic signed [c_aw-1:0]      r_sum;
  logic                        r_sum_valid;
  logic signed [c_aw-1:0]      w_prod;
  logic signed [c_aw-1:0]      w_acc_base;
  logic signed [c_aw-1:0]      w_acc_next;

  // Weight memory: write port plus read-first synchronous read on each sample
  always_ff @(posedge clk) begin
    if (bus.weight_wr_en && (int'(bus.weight_wr_addr) < numWeight))
      r_mem[bus.weight_wr_addr] <= bus.weight_wr_data;
    if (bus.x_valid)
      r_weight <= r_mem[r_raddr];
  end

  // Read address walks the weight table once per vector and wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_raddr <= '0;
    else if (bus.x_valid)
      r_raddr <= (r_raddr == c_last_addr) ? '0 : r_raddr + 1'b1;
  end

  // Stage 1: capture the sample alongside the weight read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x  <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= bus.x_valid;
      if (bus.x_valid)
        r_x <= bus.x_in;
    end
  end

  // Exact product: both operands sign-extended to the full product width
  assign w_prod = c_aw'(r_x) * c_aw'(r_weight);

  // Stage 2: register the product; holds its value across input gaps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod <= '0;
      r_v2   <= 1'b0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1)
        r_prod <= w_prod;
    end
  end

  // First product of a vector starts from the bias, later ones from acc
  assign w_acc_base = (r_idx == '0) ? r_bias : r_acc;
  assign w_acc_next = sat_add(w_acc_base, r_prod);

  // Bias register; the accumulate reads the pre-write value on a collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_bias <= '0;
    else if (bus.bias_wr_en)
      r_bias <= bus.bias_wr_data;
  end

  // Stage 3: accumulate, and emit the final sum as a one-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_acc       <= '0;
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
    end else begin
      r_sum_valid <= 1'b0;
      if (r_v2) begin
        if (r_idx == c_last_idx) begin
          r_idx       <= '0;
          r_sum       <= w_acc_next;
          r_sum_valid <= 1'b1;
        end else begin
          r_idx <= r_idx + 1'b1;
          r_acc <= w_acc_next;
        end
      end
    end
  end

  assign bus.sum_out   = r_sum;
  assign bus.sum_valid = r_sum_valid;

endmodule
`default_nettype wire
